id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath.
- Captures the decode control bundles (EX, M, WB) from the decode control unit, plus operands and register indices.
- Detects load-use hazards against the instruction currently in EX. On a hazard it inserts a bubble and raises a stall request to IF/PC/IF-ID.
- Honours a branch flush from MEM and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_WIDTH, 32, width of npc/readdat/signext paths
- REG_ADDR, 5, register index width
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- ctlex_in  input  4  {regdst, aluop[1:0], alusrc} from decode control
- ctlm_in  input  3  {branch, memread, memwrite}
- ctlwb_in  input  2  {regwrite, memtoreg}
- npc_in  input  DATA_WIDTH  next PC from IF/ID
- readdat1_in  input  DATA_WIDTH  register file port 1
- readdat2_in  input  DATA_WIDTH  register file port 2
- signext_in  input  DATA_WIDTH  sign-extended immediate
- rs_in  input  REG_ADDR  instr[25:21]
- rt_in  input  REG_ADDR  instr[20:16]
- rd_in  input  REG_ADDR  instr[15:11]
- flush  input  1  branch taken in MEM; squash the instruction entering EX
- ex_out  output  4  registered EX bundle
- m_out  output  3  registered M bundle
- wb_out  output  2  registered WB bundle
- npc_out, readdat1_out, readdat2_out, signext_out  output  DATA_WIDTH  registered data
- rt_out, rd_out  output  REG_ADDR  registered indices
- valid_out  output  1  EX holds a real (non-bubble) instruction
- stall  output  1  hold PC and IF/ID this cycle
- stall_count  output  CNT_WIDTH  number of cycles stall was high

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all outputs are 0, including valid_out, stall_count and every data and index register.
- Hazard definition (combinational from registered state plus current inputs):
  hazard = valid_out & m_out[1] & (rt_out != 0) & (rt_out == rs_in | rt_out == rt_in)
- stall = hazard & ~flush & ~rst.
- Each clock edge, in priority order:
  1. rst: clear everything.
  2. flush: ex/m/wb_out <= 0, valid_out <= 0; data and index registers capture their inputs (don't-care).
  3. hazard: bubble. Controls <= 0, valid_out <= 0, data and index registers capture their inputs.
  4. Otherwise: all registers capture their inputs; valid_out <= 1.
- valid_out is forced 0 whenever the captured ctlex/ctlm/ctlwb are all zero. This covers a NOP opcode.
- Load-use stall is exactly one cycle. After the bubble, m_out[1] = 0, so hazard drops. The held instruction re-presents and is captured next cycle.
- Back-to-back loads: a second LW whose rs/rt matches the first LW's rt stalls once, then is captured. A third dependent instruction stalls once more.
- Register $0 never causes a hazard.
- Flush and hazard in the same cycle: flush wins, stall = 0 (the wrong-path instruction is discarded, not held).
- stall_count increments by 1 on every edge where stall = 1. It saturates at all-ones and is cleared only by rst.
- Latency: inputs appear on the outputs one clock after capture. No combinational path from inputs to the registered outputs.
- Reset asserted mid-stall: on the next edge all state clears and stall drops that same cycle.

Test Plan:
- Reset: rst = 1 for 2 cycles with random inputs → all outputs 0, stall = 0, stall_count = 0.
- R-type pass-through: ctlex = 1100, ctlm = 000, ctlwb = 10, readdat1 = 0x11, rd = 5 → next cycle ex_out = 1100, wb_out = 10, readdat1_out = 0x11, rd_out = 5, valid_out = 1.
- Load-use: LW rt = 8 captured, then R-type with rs = 8 → stall = 1 for exactly one cycle, bubble (ex/m/wb = 0, valid_out = 0) in EX. Next cycle the R-type is captured and stall_count = 1.
- $0 and no-match: LW rt = 0 followed by rs = 0, and LW rt = 8 followed by rs = 9, rt = 10 → stall stays 0.
- Flush priority: LW rt = 8 in EX, dependent instruction in decode, flush = 1 → stall = 0, next-cycle controls 0, valid_out = 0, stall_count unchanged.
- Saturation: CNT_WIDTH = 2, force 5 load-use stalls → stall_count holds at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Inserts a one-cycle bubble on load-use hazards, honours MEM-stage flush, counts stall cycles.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            ctlex_in,
  input  logic [2:0]            ctlm_in,
  input  logic [1:0]            ctlwb_in,
  input  logic [DATA_WIDTH-1:0] npc_in,
  input  logic [DATA_WIDTH-1:0] readdat1_in,
  input  logic [DATA_WIDTH-1:0] readdat2_in,
  input  logic [DATA_WIDTH-1:0] signext_in,
  input  logic [REG_ADDR-1:0]   rs_in,
  input  logic [REG_ADDR-1:0]   rt_in,
  input  logic [REG_ADDR-1:0]   rd_in,
  input  logic                  flush,
  output logic [3:0]            ex_out,
  output logic [2:0]            m_out,
  output logic [1:0]            wb_out,
  output logic [DATA_WIDTH-1:0] npc_out,
  output logic [DATA_WIDTH-1:0] readdat1_out,
  output logic [DATA_WIDTH-1:0] readdat2_out,
  output logic [DATA_WIDTH-1:0] signext_out,
  output logic [REG_ADDR-1:0]   rt_out,
  output logic [REG_ADDR-1:0]   rd_out,
  output logic                  valid_out,
  output logic                  stall,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  logic [3:0]            r_ex;
  logic [2:0]            r_m;
  logic [1:0]            r_wb;
  logic [DATA_WIDTH-1:0] r_npc;
  logic [DATA_WIDTH-1:0] r_rd1;
  logic [DATA_WIDTH-1:0] r_rd2;
  logic [DATA_WIDTH-1:0] r_sext;
  logic [REG_ADDR-1:0]   r_rt;
  logic [REG_ADDR-1:0]   r_rd;
  logic                  r_valid;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  logic w_hazard;
  logic w_stall;
  logic w_bubble;
  logic w_ctl_nz;
  logic w_cnt_sat;

  // Load in EX whose destination feeds the instruction in decode; $0 is never a dependency.
  always_comb begin
    w_hazard  = r_valid & r_m[1] & (r_rt != {REG_ADDR{1'b0}}) &
                ((r_rt == rs_in) | (r_rt == rt_in));
    w_stall   = w_hazard & ~flush & ~rst;
    w_bubble  = flush | w_hazard;
    w_ctl_nz  = |{ctlex_in, ctlm_in, ctlwb_in};
    w_cnt_sat = (r_stall_cnt == {CNT_WIDTH{1'b1}});
  end

  // Pipeline register: data always advances, controls are zeroed on flush or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= 4'b0000;
      r_m         <= 3'b000;
      r_wb        <= 2'b00;
      r_npc       <= {DATA_WIDTH{1'b0}};
      r_rd1       <= {DATA_WIDTH{1'b0}};
      r_rd2       <= {DATA_WIDTH{1'b0}};
      r_sext      <= {DATA_WIDTH{1'b0}};
      r_rt        <= {REG_ADDR{1'b0}};
      r_rd        <= {REG_ADDR{1'b0}};
      r_valid     <= 1'b0;
      r_stall_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      r_npc  <= npc_in;
      r_rd1  <= readdat1_in;
      r_rd2  <= readdat2_in;
      r_sext <= signext_in;
      r_rt   <= rt_in;
      r_rd   <= rd_in;
      if (w_bubble) begin
        r_ex    <= 4'b0000;
        r_m     <= 3'b000;
        r_wb    <= 2'b00;
        r_valid <= 1'b0;
      end else begin
        r_ex    <= ctlex_in;
        r_m     <= ctlm_in;
        r_wb    <= ctlwb_in;
        r_valid <= w_ctl_nz;
      end
      // Saturating: the counter stops at all-ones until the next reset.
      if (w_stall && !w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign ex_out       = r_ex;
  assign m_out        = r_m;
  assign wb_out       = r_wb;
  assign npc_out      = r_npc;
  assign readdat1_out = r_rd1;
  assign readdat2_out = r_rd2;
  assign signext_out  = r_sext;
  assign rt_out       = r_rt;
  assign rd_out       = r_rd;
  assign valid_out    = r_valid;
  assign stall        = w_stall;
  assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against an instruction-level reference model,
// with directed load-use, $0, flush and counter-saturation scenarios.
module tb_id_ex_stage;
  localparam int DW  = 32;
  localparam int RA  = 5;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush;
  logic [3:0]    ctlex_in;
  logic [2:0]    ctlm_in;
  logic [1:0]    ctlwb_in;
  logic [DW-1:0] npc_in, readdat1_in, readdat2_in, signext_in;
  logic [RA-1:0] rs_in, rt_in, rd_in;

  logic [3:0]    ex_out, ex_out2;
  logic [2:0]    m_out, m_out2;
  logic [1:0]    wb_out, wb_out2;
  logic [DW-1:0] npc_out, readdat1_out, readdat2_out, signext_out;
  logic [DW-1:0] npc_out2, readdat1_out2, readdat2_out2, signext_out2;
  logic [RA-1:0] rt_out, rd_out, rt_out2, rd_out2;
  logic          valid_out, stall, valid_out2, stall2;
  logic [CW-1:0] stall_count;
  logic [CW2-1:0] stall_count2;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR(RA), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ctlex_in(ctlex_in), .ctlm_in(ctlm_in), .ctlwb_in(ctlwb_in),
    .npc_in(npc_in), .readdat1_in(readdat1_in), .readdat2_in(readdat2_in),
    .signext_in(signext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
    .ex_out(ex_out), .m_out(m_out), .wb_out(wb_out), .npc_out(npc_out),
    .readdat1_out(readdat1_out), .readdat2_out(readdat2_out), .signext_out(signext_out),
    .rt_out(rt_out), .rd_out(rd_out), .valid_out(valid_out), .stall(stall),
    .stall_count(stall_count)
  );

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR(RA), .CNT_WIDTH(CW2)) dut_sat (
    .clk(clk), .rst(rst), .ctlex_in(ctlex_in), .ctlm_in(ctlm_in), .ctlwb_in(ctlwb_in),
    .npc_in(npc_in), .readdat1_in(readdat1_in), .readdat2_in(readdat2_in),
    .signext_in(signext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
    .ex_out(ex_out2), .m_out(m_out2), .wb_out(wb_out2), .npc_out(npc_out2),
    .readdat1_out(readdat1_out2), .readdat2_out(readdat2_out2), .signext_out(signext_out2),
    .rt_out(rt_out2), .rd_out(rd_out2), .valid_out(valid_out2), .stall(stall2),
    .stall_count(stall_count2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the instruction sitting in EX, described as its fields.
  logic [3:0]    m_ex;
  logic [2:0]    m_m;
  logic [1:0]    m_wb;
  logic [DW-1:0] m_npc, m_rd1, m_rd2, m_se;
  logic [RA-1:0] m_rt, m_rd;
  logic          m_valid;
  int            m_cnt, m_cnt2;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                       input logic [RA-1:0] rs, input logic [RA-1:0] rt, input logic [RA-1:0] rd,
                       input logic fl, input logic r);
    ctlex_in = ex; ctlm_in = m; ctlwb_in = wb;
    rs_in = rs; rt_in = rt; rd_in = rd;
    flush = fl; rst = r;
    npc_in = $urandom; readdat1_in = $urandom; readdat2_in = $urandom; signext_in = $urandom;
  endtask

  // One clock: check stall mid-cycle, advance the model at the edge, compare registers after it.
  task automatic tick();
    logic load_dep, exp_stall;
    @(negedge clk);
    load_dep  = m_valid && m_m[1] && (m_rt != 5'd0) && (m_rt == rs_in || m_rt == rt_in);
    exp_stall = load_dep && !flush && !rst;
    check_value("stall", {63'd0, stall}, {63'd0, exp_stall});
    check_value("stall_sat", {63'd0, stall2}, {63'd0, exp_stall});
    @(posedge clk);
    if (rst) begin
      m_ex = 4'd0; m_m = 3'd0; m_wb = 2'd0; m_npc = '0; m_rd1 = '0; m_rd2 = '0; m_se = '0;
      m_rt = 5'd0; m_rd = 5'd0; m_valid = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_npc = npc_in; m_rd1 = readdat1_in; m_rd2 = readdat2_in; m_se = signext_in;
      m_rt = rt_in; m_rd = rd_in;
      if (flush || load_dep) begin
        m_ex = 4'd0; m_m = 3'd0; m_wb = 2'd0; m_valid = 1'b0;
      end else begin
        m_ex = ctlex_in; m_m = ctlm_in; m_wb = ctlwb_in;
        m_valid = (ctlex_in != 4'd0) || (ctlm_in != 3'd0) || (ctlwb_in != 2'd0);
      end
      if (exp_stall) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end
    end
    #1;
    check_value("ex_out", {60'd0, ex_out}, {60'd0, m_ex});
    check_value("m_out", {61'd0, m_out}, {61'd0, m_m});
    check_value("wb_out", {62'd0, wb_out}, {62'd0, m_wb});
    check_value("npc_out", {32'd0, npc_out}, {32'd0, m_npc});
    check_value("readdat1_out", {32'd0, readdat1_out}, {32'd0, m_rd1});
    check_value("readdat2_out", {32'd0, readdat2_out}, {32'd0, m_rd2});
    check_value("signext_out", {32'd0, signext_out}, {32'd0, m_se});
    check_value("rt_out", {59'd0, rt_out}, {59'd0, m_rt});
    check_value("rd_out", {59'd0, rd_out}, {59'd0, m_rd});
    check_value("valid_out", {63'd0, valid_out}, {63'd0, m_valid});
    check_value("stall_count", {48'd0, stall_count}, 64'(m_cnt));
    check_value("stall_count_sat", {62'd0, stall_count2}, 64'(m_cnt2));
  endtask

  initial begin
    m_ex = 4'd0; m_m = 3'd0; m_wb = 2'd0; m_npc = '0; m_rd1 = '0; m_rd2 = '0; m_se = '0;
    m_rt = 5'd0; m_rd = 5'd0; m_valid = 1'b0; m_cnt = 0; m_cnt2 = 0;

    // Reset with random inputs
    drive(4'($urandom), 3'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          1'b0, 1'b1);
    tick();
    tick();
    check_value("rst_valid", {63'd0, valid_out}, 64'd0);
    check_value("rst_count", {48'd0, stall_count}, 64'd0);
    check_value("rst_ex", {60'd0, ex_out}, 64'd0);

    // R-type pass-through
    drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    readdat1_in = 32'h11;
    tick();
    check_value("rtype_ex", {60'd0, ex_out}, 64'hC);
    check_value("rtype_wb", {62'd0, wb_out}, 64'h2);
    check_value("rtype_rd1", {32'd0, readdat1_out}, 64'h11);
    check_value("rtype_rd", {59'd0, rd_out}, 64'd5);
    check_value("rtype_valid", {63'd0, valid_out}, 64'd1);

    // Load-use: one stall cycle, bubble, then the held R-type is captured
    drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    tick();
    drive(4'b1100, 3'b000, 2'b10, 5'd8, 5'd3, 5'd4, 1'b0, 1'b0);
    #2;
    check_value("lu_stall", {63'd0, stall}, 64'd1);
    tick();
    check_value("lu_bubble_ex", {60'd0, ex_out}, 64'd0);
    check_value("lu_bubble_valid", {63'd0, valid_out}, 64'd0);
    #2;
    check_value("lu_stall_drop", {63'd0, stall}, 64'd0);
    tick();
    check_value("lu_capture_ex", {60'd0, ex_out}, 64'hC);
    check_value("lu_capture_valid", {63'd0, valid_out}, 64'd1);
    check_value("lu_count", {48'd0, stall_count}, 64'd1);

    // $0 destination and non-matching sources never stall
    drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(4'b1100, 3'b000, 2'b10, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
    #2;
    check_value("zero_reg_stall", {63'd0, stall}, 64'd0);
    tick();
    drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    tick();
    drive(4'b1100, 3'b000, 2'b10, 5'd9, 5'd10, 5'd6, 1'b0, 1'b0);
    #2;
    check_value("nomatch_stall", {63'd0, stall}, 64'd0);
    tick();

    // Flush beats hazard
    drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    tick();
    drive(4'b1100, 3'b000, 2'b10, 5'd8, 5'd3, 5'd4, 1'b1, 1'b0);
    #2;
    check_value("flush_stall", {63'd0, stall}, 64'd0);
    tick();
    check_value("flush_ex", {60'd0, ex_out}, 64'd0);
    check_value("flush_valid", {63'd0, valid_out}, 64'd0);
    check_value("flush_count", {48'd0, stall_count}, 64'd1);

    // Five load-use stalls saturate the 2-bit counter at 3
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
      tick();
      drive(4'b1100, 3'b000, 2'b10, 5'd2, 5'd8, 5'd4, 1'b0, 1'b0);
      tick();
      tick();
    end
    check_value("sat_count2", {62'd0, stall_count2}, 64'd3);
    check_value("sat_count16", {48'd0, stall_count}, 64'd6);

    // Reset during a stall drops stall immediately
    drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    tick();
    drive(4'b1100, 3'b000, 2'b10, 5'd8, 5'd3, 5'd4, 1'b0, 1'b1);
    #2;
    check_value("rst_mid_stall", {63'd0, stall}, 64'd0);
    tick();
    check_value("rst_mid_count", {48'd0, stall_count}, 64'd0);

    // Random traffic with a small register pool so dependencies are frequent
    for (int i = 0; i < 600; i++) begin
      drive(4'($urandom), 3'($urandom), 2'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 3) == 0) begin
        ctlex_in = 4'd0; ctlm_in = 3'd0; ctlwb_in = 2'd0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
